// File: rtl/rdma_regs_pkg.sv
// Shared register map, CTRL field layout and constants for the RDMA TX register file.
package rdma_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] IDX_CTRL           = 7'h00;
    localparam logic [ADDR_W-1:0] IDX_IRQ_CTRL       = 7'h01;
    localparam logic [ADDR_W-1:0] IDX_IRQ_STATUS     = 7'h02;
    localparam logic [ADDR_W-1:0] IDX_STATUS         = 7'h03;
    localparam logic [ADDR_W-1:0] IDX_VERSION        = 7'h04;
    localparam logic [ADDR_W-1:0] IDX_SQ_BASE_LO     = 7'h08;
    localparam logic [ADDR_W-1:0] IDX_SQ_BASE_HI     = 7'h09;
    localparam logic [ADDR_W-1:0] IDX_SQ_SIZE        = 7'h0A;
    localparam logic [ADDR_W-1:0] IDX_SQ_HEAD        = 7'h0B;
    localparam logic [ADDR_W-1:0] IDX_SQ_TAIL        = 7'h0C;
    localparam logic [ADDR_W-1:0] IDX_SQ_DOORBELL    = 7'h0D;
    localparam logic [ADDR_W-1:0] IDX_SQ_FLAGS       = 7'h0E;
    localparam logic [ADDR_W-1:0] IDX_SQ_STRIDE      = 7'h0F;
    localparam logic [ADDR_W-1:0] IDX_CQ_BASE_LO     = 7'h10;
    localparam logic [ADDR_W-1:0] IDX_CQ_BASE_HI     = 7'h11;
    localparam logic [ADDR_W-1:0] IDX_CQ_SIZE        = 7'h12;
    localparam logic [ADDR_W-1:0] IDX_CQ_TAIL        = 7'h13;
    localparam logic [ADDR_W-1:0] IDX_CQ_HEAD_SW     = 7'h14;
    localparam logic [ADDR_W-1:0] IDX_CQ_DOORBELL    = 7'h15;
    localparam logic [ADDR_W-1:0] IDX_CQ_FLAGS       = 7'h16;
    localparam logic [ADDR_W-1:0] IDX_BYTES_LO       = 7'h18;
    localparam logic [ADDR_W-1:0] IDX_BYTES_HI       = 7'h19;
    localparam logic [ADDR_W-1:0] IDX_WQE_PROCESSED  = 7'h1A;
    localparam logic [ADDR_W-1:0] IDX_CQE_WRITTEN    = 7'h1B;
    localparam logic [ADDR_W-1:0] IDX_CYCLES_BUSY_LO = 7'h1C;
    localparam logic [ADDR_W-1:0] IDX_CYCLES_BUSY_HI = 7'h1D;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_SRST_BIT   = 1;
    localparam int unsigned CTRL_PAUSE_BIT  = 2;
    localparam int unsigned CTRL_MODE_LSB   = 4;
    localparam int unsigned CTRL_MODE_MSB   = 7;
    localparam logic [DATA_W-1:0] CTRL_MASK = 32'h0000_00F7;

    localparam logic [DATA_W-1:0] VERSION   = 32'h0001_0000;
    localparam logic [1:0]        RESP_OKAY = 2'b00;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rdma_registers_axil.sv
// AXI4-Lite register file for the RDMA TX engine: ring config, control, doorbells, HW status.
// Optional interrupt logic is enabled by defining RDMA_REGS_IRQ_EN.
module rdma_registers_axil
    import rdma_regs_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [31:0]                       SQ_BASE_LO,
    output logic [31:0]                       SQ_BASE_HI,
    output logic [31:0]                       SQ_SIZE,
    output logic [31:0]                       SQ_TAIL,
    output logic [31:0]                       SQ_FLAGS,
    output logic [31:0]                       SQ_STRIDE,
    output logic [31:0]                       CQ_BASE_LO,
    output logic [31:0]                       CQ_BASE_HI,
    output logic [31:0]                       CQ_SIZE,
    output logic [31:0]                       CQ_HEAD_SW,
    output logic [31:0]                       CQ_FLAGS,
    output logic                              SQ_DOORBELL_PULSE,
    output logic                              CQ_DOORBELL_PULSE,
    output logic                              GLOBAL_ENABLE,
    output logic                              SOFT_RESET,
    output logic                              PAUSE,
    output logic [3:0]                        MODE,
    output logic                              GLOBAL_IRQ_EN,
    output logic                              IRQ_OUT,
    input  logic [31:0]                       HW_SQ_HEAD,
    input  logic [31:0]                       HW_CQ_TAIL,
    input  logic [31:0]                       HW_STATUS_WORD,
    input  logic [31:0]                       HW_BYTES_LO,
    input  logic [31:0]                       HW_BYTES_HI,
    input  logic [31:0]                       HW_WQE_PROCESSED,
    input  logic [31:0]                       HW_CQE_WRITTEN,
    input  logic [31:0]                       HW_CYCLES_BUSY_LO,
    input  logic [31:0]                       HW_CYCLES_BUSY_HI
);

    logic              r_awready, r_bvalid, r_arready, r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_ctrl;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_sq_base_lo, r_sq_base_hi, r_sq_size, r_sq_tail, r_sq_flags, r_sq_stride;
    logic [DATA_W-1:0] r_cq_base_lo, r_cq_base_hi, r_cq_size, r_cq_head_sw, r_cq_flags;
    logic              r_sq_db, r_cq_db;

    logic              w_wr_start, w_wr_fire, w_rd_start, w_rd_fire;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [DATA_W-1:0] w_rd_mux;
    logic              w_irq_status_rd;
    logic              w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_waddr    = ADDR_W'(S_AXI_AWADDR);
    assign w_raddr    = ADDR_W'(S_AXI_ARADDR);
    // READY is raised one cycle after both valids are seen; the transfer lands while it is high.
    assign w_wr_start = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
    assign w_wr_fire  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_start = S_AXI_ARVALID & ~r_rvalid & ~r_arready;
    assign w_rd_fire  = r_arready & S_AXI_ARVALID;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_awready    <= 1'b0;
            r_bvalid     <= 1'b0;
            r_ctrl       <= '0;
            r_irq_en     <= 1'b0;
            r_sq_base_lo <= '0;
            r_sq_base_hi <= '0;
            r_sq_size    <= '0;
            r_sq_tail    <= '0;
            r_sq_flags   <= '0;
            r_sq_stride  <= '0;
            r_cq_base_lo <= '0;
            r_cq_base_hi <= '0;
            r_cq_size    <= '0;
            r_cq_head_sw <= '0;
            r_cq_flags   <= '0;
            r_sq_db      <= 1'b0;
            r_cq_db      <= 1'b0;
        end else begin
            r_awready <= w_wr_start;
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            else if (S_AXI_BREADY)
                r_bvalid <= 1'b0;
            r_sq_db <= w_wr_fire && (w_waddr == IDX_SQ_TAIL || w_waddr == IDX_SQ_DOORBELL);
            r_cq_db <= w_wr_fire && (w_waddr == IDX_CQ_HEAD_SW || w_waddr == IDX_CQ_DOORBELL);
            if (w_wr_fire) begin
                case (w_waddr)
                    IDX_CTRL:       r_ctrl       <= apply_wstrb(r_ctrl, S_AXI_WDATA, S_AXI_WSTRB) & CTRL_MASK;
                    IDX_IRQ_CTRL:   if (S_AXI_WSTRB[0]) r_irq_en <= S_AXI_WDATA[0];
                    IDX_SQ_BASE_LO: r_sq_base_lo <= apply_wstrb(r_sq_base_lo, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_SQ_BASE_HI: r_sq_base_hi <= apply_wstrb(r_sq_base_hi, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_SQ_SIZE:    r_sq_size    <= apply_wstrb(r_sq_size, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_SQ_TAIL:    r_sq_tail    <= apply_wstrb(r_sq_tail, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_SQ_FLAGS:   r_sq_flags   <= apply_wstrb(r_sq_flags, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_SQ_STRIDE:  r_sq_stride  <= apply_wstrb(r_sq_stride, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_CQ_BASE_LO: r_cq_base_lo <= apply_wstrb(r_cq_base_lo, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_CQ_BASE_HI: r_cq_base_hi <= apply_wstrb(r_cq_base_hi, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_CQ_SIZE:    r_cq_size    <= apply_wstrb(r_cq_size, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_CQ_HEAD_SW: r_cq_head_sw <= apply_wstrb(r_cq_head_sw, S_AXI_WDATA, S_AXI_WSTRB);
                    IDX_CQ_FLAGS:   r_cq_flags   <= apply_wstrb(r_cq_flags, S_AXI_WDATA, S_AXI_WSTRB);
                    default: ;
                endcase
            end
        end
    end

    // Read data mux; RO registers are sampled live from the HW inputs.
    always_comb begin
        w_rd_mux = '0;
        case (w_raddr)
            IDX_CTRL:           w_rd_mux = r_ctrl;
            IDX_IRQ_CTRL:       w_rd_mux = {31'd0, r_irq_en};
            IDX_IRQ_STATUS:     w_rd_mux = {31'd0, w_irq_status_rd};
            IDX_STATUS:         w_rd_mux = HW_STATUS_WORD;
            IDX_VERSION:        w_rd_mux = VERSION;
            IDX_SQ_BASE_LO:     w_rd_mux = r_sq_base_lo;
            IDX_SQ_BASE_HI:     w_rd_mux = r_sq_base_hi;
            IDX_SQ_SIZE:        w_rd_mux = r_sq_size;
            IDX_SQ_HEAD:        w_rd_mux = HW_SQ_HEAD;
            IDX_SQ_TAIL:        w_rd_mux = r_sq_tail;
            IDX_SQ_FLAGS:       w_rd_mux = r_sq_flags;
            IDX_SQ_STRIDE:      w_rd_mux = r_sq_stride;
            IDX_CQ_BASE_LO:     w_rd_mux = r_cq_base_lo;
            IDX_CQ_BASE_HI:     w_rd_mux = r_cq_base_hi;
            IDX_CQ_SIZE:        w_rd_mux = r_cq_size;
            IDX_CQ_TAIL:        w_rd_mux = HW_CQ_TAIL;
            IDX_CQ_HEAD_SW:     w_rd_mux = r_cq_head_sw;
            IDX_CQ_FLAGS:       w_rd_mux = r_cq_flags;
            IDX_BYTES_LO:       w_rd_mux = HW_BYTES_LO;
            IDX_BYTES_HI:       w_rd_mux = HW_BYTES_HI;
            IDX_WQE_PROCESSED:  w_rd_mux = HW_WQE_PROCESSED;
            IDX_CQE_WRITTEN:    w_rd_mux = HW_CQE_WRITTEN;
            IDX_CYCLES_BUSY_LO: w_rd_mux = HW_CYCLES_BUSY_LO;
            IDX_CYCLES_BUSY_HI: w_rd_mux = HW_CYCLES_BUSY_HI;
            default:            w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= w_rd_start;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

`ifdef RDMA_REGS_IRQ_EN
    logic [31:0] r_cq_tail_prev;
    logic        r_irq_status;
    logic        r_irq_out;
    logic        w_irq_set, w_irq_clr, w_irq_status_nxt, w_irq_en_nxt;

    assign w_irq_set        = (HW_CQ_TAIL != r_cq_tail_prev);
    assign w_irq_clr        = w_wr_fire && (w_waddr == IDX_IRQ_STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    assign w_irq_status_nxt = w_irq_set | (r_irq_status & ~w_irq_clr);
    assign w_irq_en_nxt     = (w_wr_fire && (w_waddr == IDX_IRQ_CTRL) && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0] : r_irq_en;

    // Sticky CQ-tail-moved flag; set beats a simultaneous W1C clear.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_cq_tail_prev <= '0;
            r_irq_status   <= 1'b0;
            r_irq_out      <= 1'b0;
        end else begin
            r_cq_tail_prev <= HW_CQ_TAIL;
            r_irq_status   <= w_irq_status_nxt;
            r_irq_out      <= w_irq_en_nxt & w_irq_status_nxt;
        end
    end

    assign w_irq_status_rd = r_irq_status;
    assign IRQ_OUT         = r_irq_out;
`else
    assign w_irq_status_rd = 1'b0;
    assign IRQ_OUT         = 1'b0;
`endif

    assign S_AXI_AWREADY     = r_awready;
    assign S_AXI_WREADY      = r_awready;
    assign S_AXI_BRESP       = RESP_OKAY;
    assign S_AXI_BVALID      = r_bvalid;
    assign S_AXI_ARREADY     = r_arready;
    assign S_AXI_RDATA       = C_S_AXI_DATA_WIDTH'(r_rdata);
    assign S_AXI_RRESP       = RESP_OKAY;
    assign S_AXI_RVALID      = r_rvalid;
    assign SQ_BASE_LO        = r_sq_base_lo;
    assign SQ_BASE_HI        = r_sq_base_hi;
    assign SQ_SIZE           = r_sq_size;
    assign SQ_TAIL           = r_sq_tail;
    assign SQ_FLAGS          = r_sq_flags;
    assign SQ_STRIDE         = r_sq_stride;
    assign CQ_BASE_LO        = r_cq_base_lo;
    assign CQ_BASE_HI        = r_cq_base_hi;
    assign CQ_SIZE           = r_cq_size;
    assign CQ_HEAD_SW        = r_cq_head_sw;
    assign CQ_FLAGS          = r_cq_flags;
    assign SQ_DOORBELL_PULSE = r_sq_db;
    assign CQ_DOORBELL_PULSE = r_cq_db;
    assign GLOBAL_ENABLE     = r_ctrl[CTRL_ENABLE_BIT];
    assign SOFT_RESET        = r_ctrl[CTRL_SRST_BIT];
    assign PAUSE             = r_ctrl[CTRL_PAUSE_BIT];
    assign MODE              = r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign GLOBAL_IRQ_EN     = r_irq_en;

endmodule

// File: tb/tb_rdma_registers_axil.sv
// Directed self-checking bench for rdma_registers_axil (covers both RDMA_REGS_IRQ_EN builds).
module tb_rdma_registers_axil;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] sq_base_lo, sq_base_hi, sq_size, sq_tail, sq_flags, sq_stride;
    logic [31:0] cq_base_lo, cq_base_hi, cq_size, cq_head_sw, cq_flags;
    logic        sq_db, cq_db, g_en, s_rst, pause, g_irq_en, irq_out;
    logic [3:0]  mode;
    logic [31:0] hw_sq_head, hw_cq_tail, hw_status, hw_bytes_lo, hw_bytes_hi;
    logic [31:0] hw_wqe, hw_cqe, hw_busy_lo, hw_busy_hi;

    int n_vec = 0;
    int n_err = 0;
    int sq_db_cnt = 0;
    int cq_db_cnt = 0;
    logic [31:0] rd;
    int db0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sq_db === 1'b1) sq_db_cnt++;
        if (cq_db === 1'b1) cq_db_cnt++;
    end

    rdma_registers_axil dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .SQ_BASE_LO(sq_base_lo), .SQ_BASE_HI(sq_base_hi), .SQ_SIZE(sq_size), .SQ_TAIL(sq_tail),
        .SQ_FLAGS(sq_flags), .SQ_STRIDE(sq_stride),
        .CQ_BASE_LO(cq_base_lo), .CQ_BASE_HI(cq_base_hi), .CQ_SIZE(cq_size), .CQ_HEAD_SW(cq_head_sw),
        .CQ_FLAGS(cq_flags),
        .SQ_DOORBELL_PULSE(sq_db), .CQ_DOORBELL_PULSE(cq_db),
        .GLOBAL_ENABLE(g_en), .SOFT_RESET(s_rst), .PAUSE(pause), .MODE(mode),
        .GLOBAL_IRQ_EN(g_irq_en), .IRQ_OUT(irq_out),
        .HW_SQ_HEAD(hw_sq_head), .HW_CQ_TAIL(hw_cq_tail), .HW_STATUS_WORD(hw_status),
        .HW_BYTES_LO(hw_bytes_lo), .HW_BYTES_HI(hw_bytes_hi), .HW_WQE_PROCESSED(hw_wqe),
        .HW_CQE_WRITTEN(hw_cqe), .HW_CYCLES_BUSY_LO(hw_busy_lo), .HW_CYCLES_BUSY_HI(hw_busy_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        bit hs = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin hs = 1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("aw_handshake", 32'(hs), 32'd1);
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid === 1'b1) begin hs = 1; break; end
            @(negedge clk);
        end
        chk("bvalid_seen", 32'(hs), 32'd1);
        chk("bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
        bit hs = 0;
        d = 32'hxxxx_xxxx;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready === 1'b1) begin hs = 1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid === 1'b1) begin hs = 1; break; end
            @(negedge clk);
        end
        chk("rvalid_seen", 32'(hs), 32'd1);
        chk("rresp", 32'(rresp), 32'd0);
        d = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b010;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        hw_sq_head = 0; hw_cq_tail = 0; hw_status = 32'h0000_00A5; hw_bytes_lo = 0; hw_bytes_hi = 0;
        hw_wqe = 32'd17; hw_cqe = 32'd9; hw_busy_lo = 0; hw_busy_hi = 0;
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(1);

        // Reset state
        chk("rst_sq_base_lo", sq_base_lo, 32'd0);
        chk("rst_ctrl_bits", {25'd0, mode, pause, s_rst, g_en}, 32'd0);
        chk("rst_handshake", {28'd0, awready, bvalid, arready, rvalid}, 32'd0);
        chk("rst_irq_out", {31'd0, irq_out}, 32'd0);
        chk("rst_doorbells", {30'd0, sq_db, cq_db}, 32'd0);

        // SQ ring config
        axi_write(7'h08, 32'h8000_0000, 4'hF);
        axi_write(7'h09, 32'h0000_0000, 4'hF);
        axi_write(7'h0A, 32'd64, 4'hF);
        chk("sq_base_lo", sq_base_lo, 32'h8000_0000);
        chk("sq_base_hi", sq_base_hi, 32'd0);
        chk("sq_size", sq_size, 32'd64);

        // SQ doorbells
        db0 = sq_db_cnt;
        axi_write(7'h0C, 32'd1, 4'hF);
        wait_cycles(3);
        chk("sq_tail", sq_tail, 32'd1);
        chk("sq_db_tail_pulses", 32'(sq_db_cnt - db0), 32'd1);
        db0 = sq_db_cnt;
        axi_write(7'h0D, 32'd1, 4'hF);
        wait_cycles(3);
        chk("sq_db_pulses", 32'(sq_db_cnt - db0), 32'd1);
        chk("sq_tail_unchanged", sq_tail, 32'd1);

        // CQ doorbell, WO readback
        db0 = cq_db_cnt;
        axi_write(7'h15, 32'd1, 4'hF);
        wait_cycles(3);
        chk("cq_db_pulses", 32'(cq_db_cnt - db0), 32'd1);
        axi_read(7'h15, rd);
        chk("cq_doorbell_read", rd, 32'd0);
        db0 = cq_db_cnt;
        axi_write(7'h14, 32'd7, 4'hF);
        wait_cycles(3);
        chk("cq_head_sw", cq_head_sw, 32'd7);
        chk("cq_head_db_pulses", 32'(cq_db_cnt - db0), 32'd1);

        // RO registers
        hw_sq_head = 32'd5;
        axi_read(7'h0B, rd);
        chk("sq_head_ro", rd, 32'd5);
        hw_bytes_lo = 32'hDEAD_BEEF; hw_bytes_hi = 32'd1;
        axi_read(7'h18, rd);
        chk("bytes_lo", rd, 32'hDEAD_BEEF);
        axi_read(7'h19, rd);
        chk("bytes_hi", rd, 32'h0000_0001);
        axi_read(7'h1A, rd);
        chk("wqe_processed", rd, 32'd17);
        axi_read(7'h03, rd);
        chk("status", rd, 32'h0000_00A5);
        axi_read(7'h04, rd);
        chk("version", rd, 32'h0001_0000);

        // RO write ignored, partial strobe
        axi_write(7'h0B, 32'h55, 4'hF);
        axi_read(7'h0B, rd);
        chk("sq_head_ro_write", rd, 32'd5);
        axi_write(7'h0A, 32'hAABB_CCDD, 4'b0001);
        chk("sq_size_strb", sq_size, 32'h0000_00DD);
        axi_write(7'h0F, 32'h1122_3344, 4'b1010);
        axi_read(7'h0F, rd);
        chk("sq_stride_strb", rd, 32'h1100_3300);

        // Unmapped indices
        axi_write(7'h05, 32'hFFFF_FFFF, 4'hF);
        axi_read(7'h05, rd);
        chk("unmapped_05", rd, 32'd0);
        axi_read(7'h7F, rd);
        chk("unmapped_7f", rd, 32'd0);

        // CTRL field mapping
        axi_write(7'h00, 32'hFFFF_FFFF, 4'hF);
        axi_read(7'h00, rd);
        chk("ctrl_read", rd, 32'h0000_00F7);
        chk("ctrl_outputs", {25'd0, mode, pause, s_rst, g_en}, 32'h0000_007F);
        axi_write(7'h00, 32'h0000_0031, 4'hF);
        chk("ctrl_outputs2", {25'd0, mode, pause, s_rst, g_en}, 32'h0000_0019);

        // Interrupt path
        axi_write(7'h01, 32'd1, 4'hF);
        chk("global_irq_en", {31'd0, g_irq_en}, 32'd1);
        hw_cq_tail = 32'd3;
        wait_cycles(3);
`ifdef RDMA_REGS_IRQ_EN
        chk("irq_out_set", {31'd0, irq_out}, 32'd1);
        axi_read(7'h02, rd);
        chk("irq_status_set", rd, 32'd1);
        axi_write(7'h02, 32'd1, 4'hF);
        wait_cycles(1);
        chk("irq_out_cleared", {31'd0, irq_out}, 32'd0);
        axi_read(7'h02, rd);
        chk("irq_status_cleared", rd, 32'd0);
`else
        chk("irq_out_tied", {31'd0, irq_out}, 32'd0);
        axi_read(7'h02, rd);
        chk("irq_status_zero", rd, 32'd0);
`endif
        axi_read(7'h13, rd);
        chk("cq_tail_ro", rd, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
